// File: rtl/display_controller_pkg.sv
// Shared constants for the display controller: Display decoder codes and
// controller state encodings.
package display_controller_pkg;

  // Codes understood by the Display decoder beyond the decimal digits 0-9.
  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Controller state encodings.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CONVERT = 2'd1;
  localparam state_t ST_FORMAT  = 2'd2;

endpackage

// File: rtl/display_controller_bcd_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add 3 when the digit is 5 or above, pass it through otherwise.
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/display_controller.sv
// Binary-to-seven-segment-digit controller. A captured value is converted to
// BCD with a sequential shift-add-3 loop (one bit per cycle), then formatted
// with sign and leading-zero handling. The previous result stays on the
// outputs until the new one is loaded on the FORMAT->IDLE edge.
//
// Handshake: a value is taken on any rising edge where in_valid & in_ready.
// in_ready is high exactly while the controller is IDLE (including the done
// cycle). in_valid while busy is ignored and nothing is queued.
module display_controller
  import display_controller_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 8,
  parameter int LZ_BLANK = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_signed,
  output logic [4*DIGITS-1:0]   digit_code,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic [4*DIGITS-1:0] code_q, code_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] fmt_code;
  logic [DIGITS-1:0]   fmt_en;
  logic                fmt_ovf;
  int                  msd;

  // Per-digit +3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Formatting of the finished BCD value: leading zeros, sign and overflow.
  always_comb begin
    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    fmt_ovf  = ovf_q;
    fmt_code = '0;
    fmt_en   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i <= msd) begin
        fmt_code[4*i +: 4] = bcd_q[4*i +: 4];
        fmt_en[i]          = 1'b1;
      end else if (LZ_BLANK != 0) begin
        fmt_code[4*i +: 4] = CODE_BLANK;
      end else begin
        fmt_code[4*i +: 4] = 4'd0;
        fmt_en[i]          = 1'b1;
      end
    end
    // With blanking the sign sits just above the MSD; without it, in the top
    // digit. Either way there is no room when the MSD is already the top digit.
    if (neg_q) begin
      if (msd >= DIGITS - 1) begin
        fmt_ovf = 1'b1;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if ((LZ_BLANK != 0 && i == msd + 1) || (LZ_BLANK == 0 && i == DIGITS - 1)) begin
            fmt_code[4*i +: 4] = CODE_MINUS;
            fmt_en[i]          = 1'b1;
          end
        end
      end
    end
    if (fmt_ovf) begin
      fmt_code = {DIGITS{CODE_MINUS}};
      fmt_en   = '1;
    end
  end

  // Next-state logic for the IDLE -> CONVERT -> FORMAT -> IDLE sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    code_d     = code_q;
    en_d       = en_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CONVERT;
          cnt_d   = CNT_W'(WIDTH - 1);
          neg_d   = in_signed & in_value[WIDTH-1];
          // The most negative value negates to itself, which is the correct
          // unsigned magnitude in WIDTH bits.
          mag_d   = neg_d ? -in_value : in_value;
          bcd_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_CONVERT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        ovf_d          = ovf_q | bcd_adj[4*DIGITS-1];
        if (cnt_q == '0) state_d = ST_FORMAT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FORMAT: begin
        state_d    = ST_IDLE;
        code_d     = fmt_code;
        en_d       = fmt_en;
        overflow_d = fmt_ovf;
        done_d     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      code_q     <= {DIGITS{CODE_BLANK}};
      en_q       <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      code_q     <= code_d;
      en_q       <= en_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign digit_code = code_q;
  assign digit_en   = en_q;
  assign dbg_state  = state_q;

endmodule
